rom_region_loader: RTL and testbench

- Parametrised successor to the single-region ROM download path in the arcade top level.
- Accepts the hps_io ioctl byte stream and decodes the ROM file address into NUM_REGIONS independent ROM regions.
- Paces writes with ioctl_wait, holds the game core in reset for the whole load plus a programmable tail, and reports completion and error status.
- Sits between hps_io and the game core, inside the emu top.

---
 rtl/rom_loader_pkg.sv | 21 ++
 rtl/rom_region_decode.sv | 33 +++
 rtl/rom_region_loader.sv | 169 ++++++++++++++++
 tb/tb_rom_region_loader.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_loader_pkg.sv
// Shared types and helpers for the ROM region loader: FSM states, file address
// width and the single-region match test.
package rom_loader_pkg;

  localparam int ADDR_FILE_W = 25;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    TAIL  = 2'd3
  } state_t;

  // Offset form avoids overflow of base+size at the top of the 25-bit space.
  function automatic logic region_hit(input logic [ADDR_FILE_W-1:0] addr,
                                      input logic [ADDR_FILE_W-1:0] base,
                                      input logic [ADDR_FILE_W-1:0] size);
    return (addr >= base) && ((addr - base) < size);
  endfunction

endpackage

// File: rtl/rom_region_decode.sv
// Combinational ROM file address decoder: one-hot region hit, any-hit flag and
// region-local offset. The lowest-numbered region wins on overlap.
module rom_region_decode
  import rom_loader_pkg::*;
#(
  parameter int NUM_REGIONS = 4,
  parameter int ADDR_W      = 14,
  parameter logic [NUM_REGIONS*ADDR_FILE_W-1:0] REGION_BASE = {NUM_REGIONS{25'h0}},
  parameter logic [NUM_REGIONS*ADDR_FILE_W-1:0] REGION_SIZE = {NUM_REGIONS{25'h1000}}
) (
  input  logic [ADDR_FILE_W-1:0] addr,
  output logic [NUM_REGIONS-1:0] hit_oh,
  output logic                   any_hit,
  output logic [ADDR_W-1:0]      offset
);

  always_comb begin
    hit_oh  = '0;
    any_hit = 1'b0;
    offset  = '0;
    // Walk from the top down so a lower region overrides a higher one.
    for (int k = NUM_REGIONS - 1; k >= 0; k--) begin
      if (region_hit(addr, REGION_BASE[k*ADDR_FILE_W +: ADDR_FILE_W],
                     REGION_SIZE[k*ADDR_FILE_W +: ADDR_FILE_W])) begin
        hit_oh    = '0;
        hit_oh[k] = 1'b1;
        any_hit   = 1'b1;
        offset    = ADDR_W'(addr - REGION_BASE[k*ADDR_FILE_W +: ADDR_FILE_W]);
      end
    end
  end

endmodule

// File: rtl/rom_region_loader.sv
// Splits the hps_io ROM download stream into NUM_REGIONS regions, paces writes
// with ioctl_wait and holds the game core in reset through load plus a tail.
//
// state | meaning
// IDLE  | core running, waiting for a ROM download
// LOAD  | download active, waiting for the next byte strobe
// WRITE | byte presented on dn_*, ioctl_wait high for WR_CYCLES
// TAIL  | download finished, counting down before releasing core_reset
module rom_region_loader
  import rom_loader_pkg::*;
#(
  parameter int NUM_REGIONS = 4,
  parameter int ADDR_W      = 14,
  parameter logic [NUM_REGIONS*ADDR_FILE_W-1:0] REGION_BASE = {NUM_REGIONS{25'h0}},
  parameter logic [NUM_REGIONS*ADDR_FILE_W-1:0] REGION_SIZE = {NUM_REGIONS{25'h1000}},
  parameter int WR_CYCLES   = 2,
  parameter int TAIL_CYCLES = 256,
  parameter logic [7:0] DL_INDEX = 8'd0
) (
  input  logic                   clk_sys,
  input  logic                   RESET_n,
  input  logic                   ioctl_download,
  input  logic [7:0]             ioctl_index,
  input  logic                   ioctl_wr,
  input  logic [ADDR_FILE_W-1:0] ioctl_addr,
  input  logic [7:0]             ioctl_dout,
  output logic                   ioctl_wait,
  output logic [ADDR_W-1:0]      dn_addr,
  output logic [7:0]             dn_data,
  output logic [NUM_REGIONS-1:0] dn_we,
  output logic                   core_reset,
  output logic                   load_done,
  output logic [ADDR_FILE_W-1:0] bytes_written,
  output logic                   unmapped_err
);

  localparam int TAIL_W = $clog2(TAIL_CYCLES + 1);
  localparam logic [TAIL_W-1:0] TAIL_LOAD = TAIL_W'(TAIL_CYCLES);
  localparam logic [3:0]        WR_LOAD   = 4'(WR_CYCLES);

  state_t                   state_q, state_d;
  logic [3:0]               wr_cnt_q, wr_cnt_d;
  logic [TAIL_W-1:0]        tail_cnt_q, tail_cnt_d;
  logic [ADDR_W-1:0]        dn_addr_q, dn_addr_d;
  logic [7:0]               dn_data_q, dn_data_d;
  logic [NUM_REGIONS-1:0]   dn_we_q, dn_we_d;
  logic                     load_done_q, load_done_d;
  logic [ADDR_FILE_W-1:0]   bytes_q, bytes_d;
  logic                     unmapped_q, unmapped_d;

  logic                     load_active;
  logic [NUM_REGIONS-1:0]   hit_oh;
  logic                     any_hit;
  logic [ADDR_W-1:0]        offset;

  assign load_active = ioctl_download && (ioctl_index == DL_INDEX);

  rom_region_decode #(
    .NUM_REGIONS (NUM_REGIONS),
    .ADDR_W      (ADDR_W),
    .REGION_BASE (REGION_BASE),
    .REGION_SIZE (REGION_SIZE)
  ) u_decode (
    .addr    (ioctl_addr),
    .hit_oh  (hit_oh),
    .any_hit (any_hit),
    .offset  (offset)
  );

  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    tail_cnt_d  = tail_cnt_q;
    dn_addr_d   = dn_addr_q;
    dn_data_d   = dn_data_q;
    dn_we_d     = dn_we_q;
    load_done_d = load_done_q;
    bytes_d     = bytes_q;
    unmapped_d  = unmapped_q;
    case (state_q)
      IDLE: begin
        if (load_active) begin
          state_d    = LOAD;
          bytes_d    = '0;
          unmapped_d = 1'b0;
        end
      end
      LOAD: begin
        if (!load_active) begin
          state_d    = TAIL;
          tail_cnt_d = TAIL_LOAD;
        end else if (ioctl_wr) begin
          if (any_hit) begin
            state_d   = WRITE;
            wr_cnt_d  = WR_LOAD;
            dn_addr_d = offset;
            dn_data_d = ioctl_dout;
            dn_we_d   = hit_oh;
            if (bytes_q != {ADDR_FILE_W{1'b1}}) bytes_d = bytes_q + 1'b1;
          end else begin
            unmapped_d = 1'b1;
          end
        end
      end
      WRITE: begin
        // A strobe while stalled is a protocol violation; the byte is dropped.
        if (ioctl_wr && load_active) unmapped_d = 1'b1;
        if (wr_cnt_q <= 4'd1) begin
          dn_we_d = '0;
          if (load_active) begin
            state_d = LOAD;
          end else begin
            state_d    = TAIL;
            tail_cnt_d = TAIL_LOAD;
          end
        end else begin
          wr_cnt_d = wr_cnt_q - 4'd1;
        end
      end
      TAIL: begin
        if (load_active) begin
          state_d    = LOAD;
          bytes_d    = '0;
          unmapped_d = 1'b0;
        end else if (tail_cnt_q <= TAIL_W'(1)) begin
          state_d     = IDLE;
          load_done_d = 1'b1;
        end else begin
          tail_cnt_d = tail_cnt_q - TAIL_W'(1);
        end
      end
      default: state_d = TAIL;
    endcase
  end

  always_ff @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q     <= TAIL;
      wr_cnt_q    <= '0;
      tail_cnt_q  <= TAIL_LOAD;
      dn_addr_q   <= '0;
      dn_data_q   <= '0;
      dn_we_q     <= '0;
      load_done_q <= 1'b0;
      bytes_q     <= '0;
      unmapped_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      tail_cnt_q  <= tail_cnt_d;
      dn_addr_q   <= dn_addr_d;
      dn_data_q   <= dn_data_d;
      dn_we_q     <= dn_we_d;
      load_done_q <= load_done_d;
      bytes_q     <= bytes_d;
      unmapped_q  <= unmapped_d;
    end
  end

  assign ioctl_wait    = (state_q == WRITE);
  assign core_reset    = (state_q != IDLE);
  assign dn_addr       = dn_addr_q;
  assign dn_data       = dn_data_q;
  assign dn_we         = dn_we_q;
  assign load_done     = load_done_q;
  assign bytes_written = bytes_q;
  assign unmapped_err  = unmapped_q;

endmodule

// File: tb/tb_rom_region_loader.sv
// Self-checking bench for rom_region_loader: directed region scenarios plus a
// randomized byte stream checked against an arithmetic region map.
module tb_rom_region_loader;

  localparam int NR   = 4;
  localparam int AW   = 14;
  localparam int WRC  = 2;
  localparam int TAIL = 256;
  localparam logic [7:0] DL = 8'd0;
  localparam logic [NR*25-1:0] BASE_P = {25'h2800, 25'h2000, 25'h1000, 25'h0000};
  localparam logic [NR*25-1:0] SIZE_P = {25'h0800, 25'h0800, 25'h1000, 25'h1000};

  int rb [NR] = '{'h0000, 'h1000, 'h2000, 'h2800};
  int rs [NR] = '{'h1000, 'h1000, 'h0800, 'h0800};

  logic          clk_sys = 1'b0;
  logic          RESET_n;
  logic          ioctl_download;
  logic [7:0]    ioctl_index;
  logic          ioctl_wr;
  logic [24:0]   ioctl_addr;
  logic [7:0]    ioctl_dout;
  logic          ioctl_wait;
  logic [AW-1:0] dn_addr;
  logic [7:0]    dn_data;
  logic [NR-1:0] dn_we;
  logic          core_reset;
  logic          load_done;
  logic [24:0]   bytes_written;
  logic          unmapped_err;

  int n_vec = 0;
  int n_err = 0;
  logic [24:0] m_bytes;
  logic        m_unmapped;

  rom_region_loader #(
    .NUM_REGIONS (NR), .ADDR_W (AW), .REGION_BASE (BASE_P), .REGION_SIZE (SIZE_P),
    .WR_CYCLES (WRC), .TAIL_CYCLES (TAIL), .DL_INDEX (DL)
  ) dut (
    .clk_sys (clk_sys), .RESET_n (RESET_n),
    .ioctl_download (ioctl_download), .ioctl_index (ioctl_index),
    .ioctl_wr (ioctl_wr), .ioctl_addr (ioctl_addr), .ioctl_dout (ioctl_dout),
    .ioctl_wait (ioctl_wait), .dn_addr (dn_addr), .dn_data (dn_data), .dn_we (dn_we),
    .core_reset (core_reset), .load_done (load_done),
    .bytes_written (bytes_written), .unmapped_err (unmapped_err)
  );

  always #5 clk_sys = ~clk_sys;

  function automatic int model_region(input logic [24:0] a);
    for (int k = 0; k < NR; k++)
      if (int'(a) >= rb[k] && int'(a) < rb[k] + rs[k]) return k;
    return -1;
  endfunction

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic wait_release(input string tag);
    int fall;
    int we_seen;
    fall = 0;
    we_seen = 0;
    for (int i = 1; i <= TAIL + 40; i++) begin
      step();
      if (dn_we != '0) we_seen++;
      if (!core_reset) begin
        fall = i;
        break;
      end
    end
    n_vec++;
    if (fall !== TAIL) begin
      n_err++;
      $display("FAIL %s tail_len: got %0d expected %0d", tag, fall, TAIL);
    end
    n_vec++;
    if (we_seen !== 0) begin
      n_err++;
      $display("FAIL %s we_in_tail: got %0d expected 0", tag, we_seen);
    end
    n_vec++;
    if (load_done !== 1'b1) begin
      n_err++;
      $display("FAIL %s load_done: got %b expected 1", tag, load_done);
    end
  endtask

  task automatic start_load(input string tag);
    ioctl_index = DL;
    ioctl_download = 1'b1;
    step();
    m_bytes = '0;
    m_unmapped = 1'b0;
    n_vec++;
    if (core_reset !== 1'b1 || bytes_written !== 25'd0 || unmapped_err !== 1'b0) begin
      n_err++;
      $display("FAIL %s load_start: got rst=%b bytes=%0h unm=%b expected 1 0 0",
               tag, core_reset, bytes_written, unmapped_err);
    end
  endtask

  // poke: strobe again while stalled; drop: end the download during the write
  task automatic write_byte(input logic [24:0] a, input logic [7:0] d,
                            input bit poke, input bit drop);
    int r;
    int wcnt;
    logic [NR-1:0] exp_we;
    logic [AW-1:0] exp_off;
    r = model_region(a);
    exp_we = '0;
    exp_off = '0;
    if (r >= 0) begin
      exp_we = NR'(1 << r);
      exp_off = AW'(int'(a) - rb[r]);
      if (m_bytes != 25'h1FFFFFF) m_bytes = m_bytes + 25'd1;
    end else begin
      m_unmapped = 1'b1;
    end
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr = 1'b1;
    step();
    ioctl_wr = (poke && r >= 0);
    if (poke && r >= 0) m_unmapped = 1'b1;
    if (drop) ioctl_download = 1'b0;
    n_vec++;
    if (dn_we !== exp_we) begin
      n_err++;
      $display("FAIL we@%0h: got %b expected %b", a, dn_we, exp_we);
    end
    if (r >= 0) begin
      n_vec++;
      if (dn_addr !== exp_off || dn_data !== d) begin
        n_err++;
        $display("FAIL wdata@%0h: got addr=%0h data=%0h expected addr=%0h data=%0h",
                 a, dn_addr, dn_data, exp_off, d);
      end
    end
    wcnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (ioctl_wait) wcnt++;
      else break;
      step();
      ioctl_wr = 1'b0;
    end
    ioctl_wr = 1'b0;
    n_vec++;
    if (wcnt !== ((r >= 0) ? WRC : 0) || dn_we !== '0) begin
      n_err++;
      $display("FAIL wait@%0h: got %0d cycles we=%b expected %0d cycles we=0",
               a, wcnt, dn_we, (r >= 0) ? WRC : 0);
    end
    n_vec++;
    if (bytes_written !== m_bytes || unmapped_err !== m_unmapped) begin
      n_err++;
      $display("FAIL status@%0h: got bytes=%0d unm=%b expected bytes=%0d unm=%b",
               a, bytes_written, unmapped_err, m_bytes, m_unmapped);
    end
  endtask

  task automatic test_reset();
    RESET_n = 1'b0;
    ioctl_download = 1'b0;
    ioctl_index = 8'd0;
    ioctl_wr = 1'b0;
    ioctl_addr = '0;
    ioctl_dout = '0;
    #23;
    n_vec++;
    if ({ioctl_wait, dn_we, dn_addr, dn_data} !== '0 || core_reset !== 1'b1 ||
        load_done !== 1'b0 || bytes_written !== 25'd0 || unmapped_err !== 1'b0) begin
      n_err++;
      $display("FAIL reset_vals: got wait=%b we=%b a=%0h d=%0h rst=%b done=%b bytes=%0h unm=%b",
               ioctl_wait, dn_we, dn_addr, dn_data, core_reset, load_done,
               bytes_written, unmapped_err);
    end
    @(posedge clk_sys);
    #1;
    RESET_n = 1'b1;
    wait_release("reset_only");
  endtask

  task automatic test_directed();
    start_load("directed");
    write_byte(25'h1005, 8'hA5, 1'b0, 1'b0);
    n_vec++;
    if (bytes_written !== 25'd1) begin
      n_err++;
      $display("FAIL first_count: got %0d expected 1", bytes_written);
    end
    write_byte(25'h3000, 8'h11, 1'b0, 1'b0);
    write_byte(25'h2FFF, 8'h5A, 1'b0, 1'b0);
    write_byte(25'h0000, 8'hC3, 1'b0, 1'b0);
    ioctl_download = 1'b0;
    step();
    wait_release("directed");
    n_vec++;
    if (unmapped_err !== 1'b1) begin
      n_err++;
      $display("FAIL unm_sticky: got %b expected 1", unmapped_err);
    end
  endtask

  task automatic test_other_index();
    int bad;
    bad = 0;
    ioctl_index = 8'd1;
    ioctl_download = 1'b1;
    for (int i = 0; i < 12; i++) begin
      ioctl_wr = i[0];
      ioctl_addr = 25'(i * 'h123);
      step();
      if (core_reset !== 1'b0 || dn_we !== '0 || ioctl_wait !== 1'b0 ||
          bytes_written !== m_bytes || unmapped_err !== m_unmapped) bad++;
    end
    ioctl_wr = 1'b0;
    ioctl_download = 1'b0;
    step();
    n_vec++;
    if (bad !== 0) begin
      n_err++;
      $display("FAIL other_index: got %0d disturbed cycles expected 0", bad);
    end
  endtask

  task automatic test_random();
    start_load("random");
    for (int n = 0; n < 40; n++) begin
      write_byte(25'($urandom_range(0, 'h33FF)), 8'($urandom_range(0, 255)),
                 ($urandom_range(0, 7) == 0), 1'b0);
      for (int g = $urandom_range(0, 3); g > 0; g--) step();
    end
    ioctl_download = 1'b0;
    step();
    wait_release("random");
  endtask

  task automatic test_drop_during_write();
    start_load("drop");
    write_byte(25'h2805, 8'h3C, 1'b0, 1'b0);
    write_byte(25'h1FFF, 8'h77, 1'b0, 1'b1);
    wait_release("drop_in_write");
  endtask

  task automatic test_back_to_back();
    start_load("b2b_first");
    for (int n = 0; n < 3; n++)
      write_byte(25'($urandom_range(0, 'h2FFF)), 8'($urandom_range(0, 255)), 1'b0, 1'b0);
    ioctl_download = 1'b0;
    step();
    for (int i = 0; i < 100; i++) step();
    n_vec++;
    if (core_reset !== 1'b1) begin
      n_err++;
      $display("FAIL mid_tail: got %b expected 1", core_reset);
    end
    start_load("b2b_second");
    write_byte(25'h0800, 8'h99, 1'b1, 1'b0);
    write_byte(25'h2400, 8'h66, 1'b0, 1'b0);
    ioctl_download = 1'b0;
    step();
    wait_release("b2b_reload");
  endtask

  task automatic test_reset_during_write();
    start_load("rst_write");
    ioctl_addr = 25'h2001;
    ioctl_dout = 8'hE7;
    ioctl_wr = 1'b1;
    step();
    ioctl_wr = 1'b0;
    n_vec++;
    if (dn_we !== 4'b0100 || ioctl_wait !== 1'b1) begin
      n_err++;
      $display("FAIL pre_reset_write: got we=%b wait=%b expected 0100 1", dn_we, ioctl_wait);
    end
    #2;
    RESET_n = 1'b0;
    #1;
    n_vec++;
    if (dn_we !== '0 || ioctl_wait !== 1'b0 || core_reset !== 1'b1 ||
        load_done !== 1'b0 || bytes_written !== 25'd0 || dn_addr !== '0 || dn_data !== '0) begin
      n_err++;
      $display("FAIL async_reset: got we=%b wait=%b rst=%b done=%b bytes=%0h a=%0h d=%0h",
               dn_we, ioctl_wait, core_reset, load_done, bytes_written, dn_addr, dn_data);
    end
    ioctl_download = 1'b0;
    @(posedge clk_sys);
    #1;
    RESET_n = 1'b1;
    wait_release("after_async_reset");
  endtask

  initial begin
    m_bytes = '0;
    m_unmapped = 1'b0;
    test_reset();
    test_directed();
    test_other_index();
    test_random();
    test_drop_during_write();
    test_back_to_back();
    test_reset_during_write();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
